// File: rtl/md_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// One shift-add (mult) or restoring-subtract (div) step per cycle, then a sign-fixup cycle.
module md_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_done;
    logic             w_busy;

    // Operand conditioning at launch. A divide by zero keeps A raw and clears
    // both sign flags so the iterations leave HI=A and LO=all ones untouched.
    logic             w_signed;
    logic             w_div;
    logic             w_dbz;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_signed = md_op[0];
    assign w_div    = md_op[1];
    assign w_dbz    = w_div & (B == '0);
    assign w_a_neg  = w_signed & A[WIDTH-1] & ~w_dbz;
    assign w_b_neg  = w_signed & B[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -A : A;
    assign w_b_mag  = w_b_neg ? -B : B;

    // Multiply step: conditional add of the multiplicand, then shift {acc,q} right.
    logic [WIDTH:0]   w_mul_sum;
    assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);

    // Divide step: shift next dividend bit into the remainder and trial-subtract.
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_div_diff;
    assign w_div_shift = {r_acc, r_q[WIDTH-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_b});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_b;

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = w_div ? S_DIV : S_MUL;
            S_MUL,
            S_DIV:   if (r_cnt == CW'(WIDTH-1)) w_state_next = S_FIX;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_cnt    <= '0;
                    r_acc    <= '0;
                    r_q      <= w_div ? w_a_mag : w_b_mag;
                    r_b      <= w_div ? w_b_mag : w_a_mag;
                    r_is_div <= w_div;
                    r_neg_q  <= w_a_neg ^ w_b_neg;
                    r_neg_r  <= w_div & w_a_neg;
                end
                S_MUL: begin
                    r_acc <= w_mul_sum[WIDTH:1];
                    r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    r_acc <= w_div_ok ? w_div_diff : w_div_shift[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], w_div_ok};
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            if (r_state == S_FIX) begin
                if (r_is_div) begin
                    r_lo <= r_neg_q ? -r_q : r_q;
                    r_hi <= r_neg_r ? -r_acc : r_acc;
                end else begin
                    {r_hi, r_lo} <= w_prod_fix;
                end
            end else if (r_state == S_IDLE && !start) begin
                if (hi_we) r_hi <= wdata;
                if (lo_we) r_lo <= wdata;
            end
        end
    end

    assign busy = w_busy;
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed-vector bench for md_sequencer: latency, results, busy/done timing and HI/LO writes.
module tb_md_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    md_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Launch one operation and follow it to completion; lat counts cycles after the start edge.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi0, lo0;
        int lat;
        hi0 = HI;
        lo0 = LO;
        start = 1'b1; md_op = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        chk({tag, " busy@1"}, 64'(busy), 64'd1);
        while (busy && lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 20) chk({tag, " hold@20"}, {HI, LO}, {hi0, lo0});
        end
        chk({tag, " latency"}, 64'(lat), 64'd34);
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " HI"}, 64'(HI), 64'(exp_hi));
        chk({tag, " LO"}, 64'(LO), 64'(exp_lo));
        @(negedge clk);
        chk({tag, " done pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int  lat;
        bit  saw_done;
        reset = 1'b1; start = 1'b0; md_op = 2'b00; A = '0; B = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset HI/LO", {HI, LO}, 64'd0);

        run_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult -2*3", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("divu 7/2",  2'b10, 32'd7, 32'd2, 32'd1, 32'd3);
        run_op("div -7/2",  2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu /0",   2'b10, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div /0",    2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div -7/0",  2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // Start wins over a same-cycle mthi; a second start and an mtlo while busy are ignored.
        start = 1'b1; md_op = 2'b00; A = 32'h0001_0000; B = 32'h0003_0000;
        hi_we = 1'b1; wdata = 32'h0000_AAAA;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        lat = 1;
        while (busy && lat < 60) begin
            @(negedge clk);
            lat++;
            start = (lat == 5);
            md_op = (lat == 5) ? 2'b10 : 2'b00;
            lo_we = (lat == 8);
            wdata = (lat == 8) ? 32'h0000_5555 : 32'h0000_AAAA;
        end
        start = 1'b0; lo_we = 1'b0;
        chk("start+mthi latency", 64'(lat), 64'd34);
        chk("start+mthi HI", 64'(HI), 64'h3);
        chk("start+mthi LO", 64'(LO), 64'h0);
        @(negedge clk);
        chk("no queued start", 64'(busy), 64'd0);

        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthi+mtlo", {HI, LO}, {32'h1234_5678, 32'h1234_5678});
        hi_we = 1'b1; wdata = 32'h0000_CAFE;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi only", {HI, LO}, {32'h0000_CAFE, 32'h1234_5678});

        // Reset in cycle 10 of a divide aborts it.
        start = 1'b1; md_op = 2'b10; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort HI/LO", {HI, LO}, 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort no done", 64'(saw_done), 64'd0);

        run_op("divu 100/7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
